// File: rtl/sr_emulator.sv
// sr_emulator: clk-domain model of a serial configuration shift register with latch, length check and readback.
// Optional load counter enabled by defining SR_EMULATOR_LOADCNT_EN; otherwise load_count reads 0.
`default_nettype none

module sr_emulator #(
    parameter int DATA_WIDTH = 170,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_sr,
    input  logic                  din_sr,
    input  logic                  load_sr,
    output logic                  dout_sr,
    output logic [DATA_WIDTH-1:0] cfg,
    output logic                  cfg_valid,
    output logic [CNT_WIDTH-1:0]  bit_cnt,
    output logic                  len_err,
    output logic [15:0]           load_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    logic clk_sr_meta_q, clk_sr_sync_q, clk_sr_hist_q;
    logic load_meta_q, load_sync_q, load_hist_q;
    logic din_meta_q, din_sync_q;
    logic [2:0] prime_q;

    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0] cfg_q, cfg_d;
    logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d, cnt_shift;
    logic                  len_err_q, len_err_d;
    state_t                state_q;

    logic clk_rise, load_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sr_meta_q <= 1'b0;
            clk_sr_sync_q <= 1'b0;
            clk_sr_hist_q <= 1'b0;
            load_meta_q   <= 1'b0;
            load_sync_q   <= 1'b0;
            load_hist_q   <= 1'b0;
            din_meta_q    <= 1'b0;
            din_sync_q    <= 1'b0;
            prime_q       <= 3'b000;
        end else begin
            clk_sr_meta_q <= clk_sr;
            clk_sr_sync_q <= clk_sr_meta_q;
            clk_sr_hist_q <= clk_sr_sync_q;
            load_meta_q   <= load_sr;
            load_sync_q   <= load_meta_q;
            load_hist_q   <= load_sync_q;
            din_meta_q    <= din_sr;
            din_sync_q    <= din_meta_q;
            prime_q       <= {prime_q[1:0], 1'b1};
        end
    end

    // Edge detection stays off until the history flops hold a real sampled
    // level, so a line already high at reset release is not seen as an edge.
    assign clk_rise  = prime_q[2] & clk_sr_sync_q & ~clk_sr_hist_q;
    assign load_rise = prime_q[2] & load_sync_q & ~load_hist_q;

    always_comb begin
        sreg_d    = sreg_q;
        cnt_shift = bit_cnt_q;
        if (clk_rise) begin
            sreg_d = {sreg_q[DATA_WIDTH-2:0], din_sync_q};
            if (bit_cnt_q != CNT_MAX)
                cnt_shift = bit_cnt_q + 1'b1;
        end
        // A coincident shift is applied before the latch and the length check.
        bit_cnt_d = load_rise ? '0 : cnt_shift;
        cfg_d     = load_rise ? sreg_d : cfg_q;
        len_err_d = len_err_q | (load_rise & (cnt_shift != CNT_FULL));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q    <= '0;
            cfg_q     <= '0;
            bit_cnt_q <= '0;
            len_err_q <= 1'b0;
        end else begin
            sreg_q    <= sreg_d;
            cfg_q     <= cfg_d;
            bit_cnt_q <= bit_cnt_d;
            len_err_q <= len_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_rise)
                        state_q <= ST_LOAD;
                    else if (clk_rise)
                        state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (load_rise)
                        state_q <= ST_LOAD;
                end
                ST_LOAD:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SR_EMULATOR_LOADCNT_EN
    logic [15:0] load_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            load_count_q <= '0;
        else if (load_rise)
            load_count_q <= load_count_q + 16'd1;
    end

    assign load_count = load_count_q;
`else
    assign load_count = '0;
`endif

    assign dout_sr   = sreg_q[DATA_WIDTH-1];
    assign cfg       = cfg_q;
    assign cfg_valid = (state_q == ST_LOAD);
    assign bit_cnt   = bit_cnt_q;
    assign len_err   = len_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_emulator.sv
// tb_sr_emulator: directed self-checking bench for sr_emulator (default 170-bit, 8-bit counter).
`default_nettype none

module tb_sr_emulator;

    localparam int DW = 170;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clk_sr = 1'b0;
    logic          din_sr = 1'b0;
    logic          load_sr = 1'b0;
    logic          dout_sr;
    logic [DW-1:0] cfg;
    logic          cfg_valid;
    logic [CW-1:0] bit_cnt;
    logic          len_err;
    logic [15:0]   load_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int vcount;

    logic [DW-1:0] pat1, pat2, pat3, rb;
    logic [15:0]   exp_lc1, exp_lc2;

    sr_emulator #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_sr     (clk_sr),
        .din_sr     (din_sr),
        .load_sr    (load_sr),
        .dout_sr    (dout_sr),
        .cfg        (cfg),
        .cfg_valid  (cfg_valid),
        .bit_cnt    (bit_cnt),
        .len_err    (len_err),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One serial bit: data set up during a 4-clk low phase, then a 4-clk high phase.
    task automatic shift_bit(input logic b);
        @(negedge clk);
        din_sr = b;
        clk_sr = 1'b0;
        repeat (4) @(negedge clk);
        clk_sr = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_sr = 1'b1;
        vcount  = 0;
        repeat (8) begin
            @(negedge clk);
            if (cfg_valid) vcount++;
        end
        load_sr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        pat1 = {85{2'b10}};
        pat2 = {10'h3C5, 160'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF};
        pat3 = {85{2'b01}};
`ifdef SR_EMULATOR_LOADCNT_EN
        exp_lc1 = 16'd1;
        exp_lc2 = 16'd2;
`else
        exp_lc1 = 16'd0;
        exp_lc2 = 16'd0;
`endif

        repeat (3) @(negedge clk);
        check("rst_cfg", cfg, '0);
        check("rst_bitcnt", bit_cnt, '0);
        check("rst_dout", dout_sr, '0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Nominal 170-bit load
        shift_word(pat1);
        check("nom_bitcnt_pre", bit_cnt, 170);
        pulse_load();
        check("nom_cfg", cfg, pat1);
        check("nom_valid_pulses", vcount, 1);
        check("nom_len_err", len_err, 0);
        check("nom_bitcnt", bit_cnt, 0);

        // Non-destructive readback, MSB first
        rb = '0;
        rb[DW-1] = dout_sr;
        for (int j = 1; j < DW; j++) begin
            shift_bit(1'b0);
            rb[DW-1-j] = dout_sr;
        end
        shift_bit(1'b0);
        check("readback", rb, pat1);
        check("readback_cfg_held", cfg, pat1);
        check("readback_dout_zero", dout_sr, 0);

        // Correct-length load of the zero word, then a short load
        pulse_load();
        check("zero_cfg", cfg, '0);
        check("zero_len_err", len_err, 0);
        for (int i = 0; i < 100; i++) shift_bit(1'b1);
        check("short_bitcnt_pre", bit_cnt, 100);
        pulse_load();
        check("short_len_err", len_err, 1);
        check("short_bitcnt", bit_cnt, 0);
        shift_word(pat1);
        pulse_load();
        check("sticky_cfg", cfg, pat1);
        check("sticky_len_err", len_err, 1);

        // Saturation
        for (int i = 0; i < 254; i++) shift_bit(1'b0);
        check("sat_254", bit_cnt, 254);
        for (int i = 0; i < 46; i++) shift_bit(1'b1);
        check("sat_300", bit_cnt, 255);
        shift_bit(1'b0);
        check("sat_hold", bit_cnt, 255);

        // Reset mid-operation; clk_sr left high across release
        for (int i = 0; i < 50; i++) shift_bit(1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_cfg", cfg, '0);
        check("mid_rst_valid", cfg_valid, 0);
        check("mid_rst_bitcnt", bit_cnt, '0);
        check("mid_rst_len_err", len_err, 0);
        check("mid_rst_load_count", load_count, '0);
        check("mid_rst_dout", dout_sr, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("release_high_no_edge", bit_cnt, '0);
        shift_word(pat2);
        check("fresh_bitcnt_pre", bit_cnt, 170);
        pulse_load();
        check("fresh_cfg", cfg, pat2);
        check("fresh_len_err", len_err, 0);
        check("fresh_load_count", load_count, exp_lc1);

        // Simultaneous clk_sr and load_sr edges on the 170th bit
        for (int i = DW - 1; i >= 1; i--) shift_bit(pat3[i]);
        @(negedge clk);
        din_sr = pat3[0];
        clk_sr = 1'b0;
        repeat (4) @(negedge clk);
        clk_sr  = 1'b1;
        load_sr = 1'b1;
        vcount  = 0;
        repeat (8) begin
            @(negedge clk);
            if (cfg_valid) vcount++;
        end
        load_sr = 1'b0;
        repeat (4) @(negedge clk);
        check("simul_cfg", cfg, pat3);
        check("simul_len_err", len_err, 0);
        check("simul_bitcnt", bit_cnt, 0);
        check("simul_valid_pulses", vcount, 1);
        check("simul_load_count", load_count, exp_lc2);
        check("simul_dout", dout_sr, pat3[DW-1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
